// File: rtl/fir_out_axis_packer.sv
// FIR output packer: round/scale/saturate y_in, buffer in a small FWFT FIFO and
// present it as an AXI4-Stream master with frame tlast and sticky drop/clip flags.
module fir_out_axis_packer #(
  parameter int unsigned IN_W       = 18,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FRAME_LEN  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_W-1:0]               y_in,
  input  logic                          y_valid,
  output logic [OUT_W-1:0]              m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          saturated,
  input  logic                          clear_flags
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned RW = IN_W + 1;
  localparam logic [RW-1:0] HALF  = RW'(1) << (SHIFT - 1);
  localparam logic [RW-1:0] MAX_S = RW'((2 ** OUT_W) - 1);

  // Rounding add is one bit wider than the input so it can never wrap.
  logic [RW-1:0]    rnd_c;
  logic [RW-1:0]    shr_c;
  logic             clip_c;
  logic [OUT_W-1:0] scaled_c;

  assign rnd_c    = {1'b0, y_in} + HALF;
  assign shr_c    = rnd_c >> SHIFT;
  assign clip_c   = shr_c > MAX_S;
  assign scaled_c = clip_c ? {OUT_W{1'b1}} : OUT_W'(shr_c);

  logic             s1_valid;
  logic [OUT_W-1:0] s1_data;

  logic [OUT_W-1:0] mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [FW-1:0]    frame_cnt;

  logic             rd_c;
  logic             full_c;
  logic             wr_c;
  logic             drop_c;
  logic [LW-1:0]    level_nxt_c;

  assign rd_c   = m_axis_tvalid & m_axis_tready;
  assign full_c = (fifo_level == LW'(FIFO_DEPTH));
  assign wr_c   = s1_valid & (~full_c | rd_c);
  assign drop_c = s1_valid & full_c & ~rd_c;

  // Occupancy update: simultaneous push and pop leave the level unchanged.
  always_comb begin
    level_nxt_c = fifo_level;
    case ({wr_c, rd_c})
      2'b10:   level_nxt_c = fifo_level + LW'(1);
      2'b01:   level_nxt_c = fifo_level - LW'(1);
      default: level_nxt_c = fifo_level;
    endcase
  end

  // Head of the FIFO is presented directly (first-word fall-through).
  assign m_axis_tdata = mem_data[rd_ptr];
  assign m_axis_tlast = mem_last[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_data       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      frame_cnt     <= '0;
      fifo_level    <= '0;
      m_axis_tvalid <= 1'b0;
      overflow      <= 1'b0;
      saturated     <= 1'b0;
      mem_last      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_data[i] <= '0;
    end else begin
      s1_valid <= y_valid;
      s1_data  <= scaled_c;

      if (wr_c) begin
        mem_data[wr_ptr] <= s1_data;
        mem_last[wr_ptr] <= (frame_cnt == FW'(FRAME_LEN - 1));
        wr_ptr           <= wr_ptr + AW'(1);
        frame_cnt        <= (frame_cnt == FW'(FRAME_LEN - 1)) ? '0 : frame_cnt + FW'(1);
      end
      if (rd_c) rd_ptr <= rd_ptr + AW'(1);

      fifo_level    <= level_nxt_c;
      m_axis_tvalid <= (level_nxt_c != '0);

      // New events take priority over a clear in the same cycle.
      if (drop_c)           overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;

      if (y_valid && clip_c) saturated <= 1'b1;
      else if (clear_flags)  saturated <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_out_axis_packer.sv
// Self-checking bench for fir_out_axis_packer against a queue-based reference model.
module tb_fir_out_axis_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] y_in = '0;
  logic        y_valid = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        saturated;
  logic        clear_flags = 1'b0;

  int checks = 0;
  int errors = 0;

  fir_out_axis_packer dut (
    .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .fifo_level(fifo_level), .overflow(overflow), .saturated(saturated),
    .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  // Reference model: queue of {last, data}, one-sample pipeline, frame index, flags.
  logic [8:0] mq[$];
  int         m_frame = 0;
  bit         m_s1v = 0;
  logic [7:0] m_s1d = '0;
  bit         m_ovf = 0;
  bit         m_sat = 0;

  function automatic logic [8:0] scale(input logic [17:0] y);
    int r;
    r = (int'(y) + 128) >>> 8;
    if (r > 255) return {1'b1, 8'hFF};
    return {1'b0, 8'(r)};
  endfunction

  task automatic model_clear();
    mq.delete();
    m_frame = 0; m_s1v = 0; m_s1d = '0; m_ovf = 0; m_sat = 0;
  endtask

  task automatic tick(input bit yv, input logic [17:0] y, input bit tr, input bit clr);
    logic [8:0] sc;
    logic [8:0] junk;
    int sz;
    bit rd, drop;
    y_in = y; y_valid = yv; m_axis_tready = tr; clear_flags = clr;
    @(posedge clk);
    sz = mq.size();
    rd = (sz != 0) && tr;
    drop = 0;
    if (rd) junk = mq.pop_front();
    if (m_s1v) begin
      if (sz < 4 || rd) begin
        mq.push_back({(m_frame == 15) ? 1'b1 : 1'b0, m_s1d});
        m_frame = (m_frame + 1) % 16;
      end else drop = 1;
    end
    sc = scale(y);
    m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_sat = (yv && sc[8]) ? 1'b1 : (clr ? 1'b0 : m_sat);
    m_s1v = yv;
    m_s1d = sc[7:0];
    #1;
  endtask

  task automatic do_reset();
    y_valid = 0; m_axis_tready = 0; clear_flags = 0; y_in = '0;
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1;
    #3;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata got %h want 00", m_axis_tdata); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m_axis_tlast); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (overflow !== 1'b0 || saturated !== 1'b0) begin errors++; $display("FAIL reset_flags got ovf=%b sat=%b want 0 0", overflow, saturated); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    tick(1, 18'h00180, 1, 0);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL single_early got tvalid=%b want 0", m_axis_tvalid); end
    tick(0, 18'h0, 1, 0);
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h02 || m_axis_tlast !== 1'b0) begin
      errors++; $display("FAIL single_out got v=%b d=%h l=%b want 1 02 0", m_axis_tvalid, m_axis_tdata, m_axis_tlast); end
    tick(0, 18'h0, 1, 0);
    checks++; if (m_axis_tvalid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++; $display("FAIL single_pop got v=%b lvl=%0d want 0 0", m_axis_tvalid, fifo_level); end
  endtask

  task automatic test_saturation();
    do_reset();
    tick(1, 18'h3FFFF, 1, 0);
    checks++; if (saturated !== 1'b1) begin errors++; $display("FAIL sat_set got %b want 1", saturated); end
    tick(0, 18'h0, 1, 0);
    checks++; if (m_axis_tdata !== 8'hFF || m_axis_tvalid !== 1'b1) begin
      errors++; $display("FAIL sat_data got v=%b d=%h want 1 ff", m_axis_tvalid, m_axis_tdata); end
    tick(0, 18'h0, 1, 1);
    checks++; if (saturated !== 1'b0) begin errors++; $display("FAIL sat_clear got %b want 0", saturated); end
    tick(1, 18'h0FF80, 1, 1);
    checks++; if (saturated !== 1'b1) begin errors++; $display("FAIL sat_set_wins got %b want 1", saturated); end
    tick(1, 18'h0FF7F, 1, 1);
    checks++; if (saturated !== 1'b0) begin errors++; $display("FAIL sat_edge_noclip got %b want 0", saturated); end
    tick(0, 18'h0, 1, 0);
    checks++; if (m_axis_tdata !== 8'hFF) begin errors++; $display("FAIL sat_edge_data got %h want ff", m_axis_tdata); end
  endtask

  task automatic test_frame();
    logic [7:0] exp_d[$];
    logic [17:0] y;
    int idx, first, last;
    do_reset();
    idx = 0; first = -1; last = -1;
    for (int c = 0; c < 40; c++) begin
      if (m_axis_tvalid) begin
        checks++; if (m_axis_tlast !== ((idx % 16) == 15) || m_axis_tdata !== exp_d[idx]) begin
          errors++; $display("FAIL frame_out[%0d] got d=%h l=%b want d=%h l=%b", idx, m_axis_tdata, m_axis_tlast, exp_d[idx], (idx % 16) == 15); end
        if (first < 0) first = c;
        last = c;
        idx++;
      end
      y = 18'($urandom_range(0, 65535));
      if (c < 32) exp_d.push_back(scale(y) & 9'h0FF);
      tick(c < 32, y, 1, 0);
    end
    checks++; if (idx !== 32 || (last - first) !== 31) begin
      errors++; $display("FAIL frame_count got n=%0d span=%0d want 32 31", idx, last - first); end
  endtask

  task automatic test_overflow();
    logic [17:0] ys[6];
    int idx;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ys[i] = 18'($urandom_range(0, 65000));
      tick(1, ys[i], 0, 0);
    end
    tick(0, 18'h0, 0, 0);
    tick(0, 18'h0, 0, 0);
    checks++; if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_state got lvl=%0d ovf=%b want 4 1", fifo_level, overflow); end
    idx = 0;
    for (int c = 0; c < 18; c++) begin
      if (m_axis_tvalid) begin
        if (idx < 4) begin
          checks++; if (m_axis_tdata !== scale(ys[idx]) & 9'h0FF || m_axis_tlast !== 1'b0) begin
            errors++; $display("FAIL ovf_drain[%0d] got d=%h l=%b want d=%h l=0", idx, m_axis_tdata, m_axis_tlast, 8'(scale(ys[idx]))); end
        end else begin
          checks++; if (m_axis_tlast !== (idx == 15) || m_axis_tdata !== mq[0][7:0]) begin
            errors++; $display("FAIL ovf_frame[%0d] got d=%h l=%b want d=%h l=%b", idx, m_axis_tdata, m_axis_tlast, mq[0][7:0], idx == 15); end
        end
        idx++;
      end
      tick((c >= 2) && (c < 14), 18'($urandom_range(0, 65535)), 1, 0);
    end
    checks++; if (idx !== 16) begin errors++; $display("FAIL ovf_total got %0d want 16", idx); end
  endtask

  task automatic test_full_stream();
    do_reset();
    for (int c = 0; c < 25; c++) begin
      tick(1, 18'($urandom_range(0, 65535)), c >= 5, 0);
      if (c >= 4) begin
        checks++; if (fifo_level !== 3'd4 || overflow !== 1'b0 || m_axis_tdata !== mq[0][7:0]) begin
          errors++; $display("FAIL full_stream[%0d] got lvl=%0d ovf=%b d=%h want 4 0 %h", c, fifo_level, overflow, m_axis_tdata, mq[0][7:0]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int idx;
    do_reset();
    for (int c = 0; c < 3; c++) tick(1, 18'($urandom_range(0, 65535)), 0, 0);
    tick(0, 18'h0, 0, 0);
    tick(0, 18'h0, 0, 0);
    checks++; if (fifo_level !== 3'd3 || m_axis_tvalid !== 1'b1) begin
      errors++; $display("FAIL mid_pre got lvl=%0d v=%b want 3 1", fifo_level, m_axis_tvalid); end
    #2;
    rst = 1;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++; $display("FAIL mid_async got v=%b lvl=%0d want 0 0", m_axis_tvalid, fifo_level); end
    @(posedge clk); #1;
    rst = 0;
    model_clear();
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_axis_tvalid) begin
        checks++; if (m_axis_tlast !== (idx == 15)) begin
          errors++; $display("FAIL mid_tlast[%0d] got %b want %b", idx, m_axis_tlast, idx == 15); end
        idx++;
      end
      tick(c < 16, 18'($urandom_range(0, 65535)), 1, 0);
    end
    checks++; if (idx !== 16) begin errors++; $display("FAIL mid_total got %0d want 16", idx); end
  endtask

  task automatic test_random();
    logic [17:0] y;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      y = ($urandom_range(0, 3) == 0) ? 18'($urandom) : 18'($urandom_range(65300, 65535));
      tick($urandom_range(0, 3) != 0, y, $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
      checks++; if (m_axis_tvalid !== (mq.size() != 0) || fifo_level !== 3'(mq.size()) ||
                    overflow !== m_ovf || saturated !== m_sat) begin
        errors++; $display("FAIL rand_ctrl[%0d] got v=%b lvl=%0d ovf=%b sat=%b want %b %0d %b %b", c,
          m_axis_tvalid, fifo_level, overflow, saturated, mq.size() != 0, mq.size(), m_ovf, m_sat); end
      if (mq.size() != 0) begin
        checks++; if (m_axis_tdata !== mq[0][7:0] || m_axis_tlast !== mq[0][8]) begin
          errors++; $display("FAIL rand_data[%0d] got d=%h l=%b want d=%h l=%b", c,
            m_axis_tdata, m_axis_tlast, mq[0][7:0], mq[0][8]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_frame();
    test_overflow();
    test_full_stream();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
